systolic_seq: RTL and testbench

Run-level sequencer for the output-stationary ROWS x COLS systolic array.
- On start, issues K operand-buffer reads (A rows, B columns).
- Generates skewed per-PE enable/first wavefronts so PE(r,c) (0-based) processes operands k=0..K-1 at the correct skew.
- Signals completion when the last PE has consumed its last operand.
- Sits between the host command interface and the PE grid plus its A/B operand buffers.

---
 rtl/systolic_seq_if.sv | 40 ++++
 rtl/systolic_seq.sv | 141 ++++++++++++++
 tb/tb_systolic_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_if.sv
// Command/status and PE-grid control bundle for the systolic_seq run sequencer.
// run_cycles is present only when SYSTOLIC_SEQ_PERF_EN is defined.
interface systolic_seq_if #(
   parameter int unsigned ROWS = 2,
   parameter int unsigned COLS = 4,
   parameter int unsigned KW   = 5,
   parameter int unsigned AW   = 4
) ();
   logic                 start;
   logic [KW-1:0]        k_len;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic                 a_rd_en;
   logic                 b_rd_en;
   logic [AW-1:0]        rd_addr;
   logic [ROWS*COLS-1:0] pe_en;
   logic [ROWS*COLS-1:0] pe_first;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [15:0]          run_cycles;

   modport master (
      output start, k_len, abort,
      input  busy, done, a_rd_en, b_rd_en, rd_addr, pe_en, pe_first, run_cycles
   );
   modport slave (
      input  start, k_len, abort,
      output busy, done, a_rd_en, b_rd_en, rd_addr, pe_en, pe_first, run_cycles
   );
`else
   modport master (
      output start, k_len, abort,
      input  busy, done, a_rd_en, b_rd_en, rd_addr, pe_en, pe_first
   );
   modport slave (
      input  start, k_len, abort,
      output busy, done, a_rd_en, b_rd_en, rd_addr, pe_en, pe_first
   );
`endif
endinterface

// File: rtl/systolic_seq.sv
// Run-level sequencer for an output-stationary ROWS x COLS systolic array: operand reads,
// skewed PE enable/first wavefronts, done pulse. Optional run_cycles via SYSTOLIC_SEQ_PERF_EN.
module systolic_seq #(
   parameter int unsigned ROWS  = 2,
   parameter int unsigned COLS  = 4,
   parameter int unsigned K_MAX = 16,
   parameter int unsigned KW    = 5,
   parameter int unsigned AW    = 4
) (
   input logic          clk,
   input logic          rst,
   systolic_seq_if.slave bus
);
   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned CW = $clog2(K_MAX + ROWS + COLS) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [KW-1:0] k_reg, k_nxt;
   logic [CW-1:0] last;

   logic          busy_nxt;
   logic          done_nxt;
   logic          rd_nxt;
   logic [AW-1:0] addr_nxt;
   logic [N-1:0]  en_nxt;
   logic [N-1:0]  first_nxt;

   // Final count of a run: operands plus array skew plus one cycle of read latency.
   assign last = CW'(k_reg) + CW'(ROWS + COLS - 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         k_reg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         k_reg <= k_nxt;
      end
   end

   // Next state, and the output values for the cycle that state/count will hold.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k_reg;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      rd_nxt    = 1'b0;
      addr_nxt  = '0;
      en_nxt    = '0;
      first_nxt = '0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.k_len == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  k_nxt     = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == last) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);

      if (busy_nxt && (cnt_nxt < CW'(k_nxt))) begin
         rd_nxt   = 1'b1;
         addr_nxt = AW'(cnt_nxt);
      end

      // PE(r,c) sees operand k at count k+1+r+c.
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (busy_nxt && (cnt_nxt >= CW'(1 + r + c)) &&
                (cnt_nxt <= CW'(k_nxt) + CW'(r + c)))
               en_nxt[r*COLS+c] = 1'b1;
            if (busy_nxt && (cnt_nxt == CW'(1 + r + c)))
               first_nxt[r*COLS+c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.a_rd_en  <= 1'b0;
         bus.b_rd_en  <= 1'b0;
         bus.rd_addr  <= '0;
         bus.pe_en    <= '0;
         bus.pe_first <= '0;
      end else begin
         bus.busy     <= busy_nxt;
         bus.done     <= done_nxt;
         bus.a_rd_en  <= rd_nxt;
         bus.b_rd_en  <= rd_nxt;
         bus.rd_addr  <= addr_nxt;
         bus.pe_en    <= en_nxt;
         bus.pe_first <= first_nxt;
      end
   end

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [16:0] run_len;

   // A zero-length run goes straight from IDLE to DONE and never raises busy.
   assign run_len = (state == IDLE) ? 17'd0 : 17'(last) + 17'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.run_cycles <= '0;
      else if (done_nxt)
         bus.run_cycles <= (run_len > 17'h0FFFF) ? 16'hFFFF : run_len[15:0];
   end
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: directed scenarios plus random traffic against a
// run-schedule model. Define SYSTOLIC_SEQ_PERF_EN to also check run_cycles.
module tb_systolic_seq;
   localparam int ROWS  = 2;
   localparam int COLS  = 4;
   localparam int K_MAX = 16;
   localparam int KW    = 5;
   localparam int AW    = 4;
   localparam int N     = ROWS * COLS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   systolic_seq_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .AW(AW)) bus ();

   systolic_seq #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .KW(KW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: m_c is the run count this cycle (-1 outside a run); m_done marks the done cycle.
   int m_c    = -1;
   int m_k    = 0;
   int m_perf = 0;
   bit m_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_c    <= -1;
         m_k    <= 0;
         m_done <= 1'b0;
         m_perf <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_c >= 0) begin
         if (bus.abort) begin
            m_c <= -1;
         end else if (m_c == m_k + ROWS + COLS - 2) begin
            m_c    <= -1;
            m_done <= 1'b1;
            m_perf <= m_k + ROWS + COLS - 1;
         end else begin
            m_c <= m_c + 1;
         end
      end else if (bus.start) begin
         if (bus.k_len == '0) begin
            m_done <= 1'b1;
            m_perf <= 0;
         end else begin
            m_k <= (int'(bus.k_len) > K_MAX) ? K_MAX : int'(bus.k_len);
            m_c <= 0;
         end
      end
   end

   int acc       = 0;
   int busy_cnt  = 0;
   int last_sum  = 0;
   int last_busy = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic [N-1:0]  e_en;
      logic [N-1:0]  e_first;
      logic [AW-1:0] e_addr;
      bit            e_busy;
      bit            e_rd;
      e_busy  = (m_c >= 0);
      e_rd    = e_busy && (m_c < m_k);
      e_addr  = e_rd ? AW'(m_c) : '0;
      e_en    = '0;
      e_first = '0;
      for (int i = 0; i < N; i++) begin
         int s;
         s = i / COLS + i % COLS;
         if (e_busy && m_c >= 1 + s && m_c <= m_k + s) e_en[i] = 1'b1;
         if (e_busy && m_c == 1 + s) e_first[i] = 1'b1;
      end
      chk("busy",     bus.busy,     e_busy);
      chk("done",     bus.done,     m_done);
      chk("a_rd_en",  bus.a_rd_en,  e_rd);
      chk("b_rd_en",  bus.b_rd_en,  e_rd);
      chk("rd_addr",  bus.rd_addr,  e_addr);
      chk("pe_en",    bus.pe_en,    e_en);
      chk("pe_first", bus.pe_first, e_first);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("run_cycles", bus.run_cycles, m_perf);
`endif
      // Per-run tallies of enable cycles and busy cycles, latched on done.
      if (bus.busy === 1'b1) begin
         acc      += $countones(bus.pe_en);
         busy_cnt += 1;
      end else if (bus.done === 1'b1) begin
         last_sum  = acc;
         last_busy = busy_cnt;
         acc       = 0;
         busy_cnt  = 0;
      end else begin
         acc      = 0;
         busy_cnt = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", bus.done, 1'b1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  bus.busy,    1'b0);
      chk("rst_done",  bus.done,    1'b0);
      chk("rst_rd",    bus.a_rd_en, 1'b0);
      chk("rst_pe_en", bus.pe_en,   8'h00);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("rst_run_cycles", bus.run_cycles, 16'd0);
`endif
      rst = 1'b0;
      tick();

      // k=3 run with literal wavefront points
      bus.start = 1'b1; bus.k_len = 5'd3;
      tick();
      bus.start = 1'b0;
      chk("t1_c0_rd",    bus.a_rd_en, 1'b1);
      chk("t1_c0_addr",  bus.rd_addr, 4'd0);
      tick();
      chk("t1_c1_en",    bus.pe_en,    8'h01);
      chk("t1_c1_first", bus.pe_first, 8'h01);
      tick();
      chk("t1_c2_addr",  bus.rd_addr, 4'd2);
      tick();
      chk("t1_c3_rd",    bus.b_rd_en, 1'b0);
      tick();
      chk("t1_c4_en",    bus.pe_en,    8'h7E);
      chk("t1_c4_first", bus.pe_first, 8'h48);
      repeat (3) tick();
      chk("t1_c7_en",    bus.pe_en, 8'h80);
      chk("t1_c7_busy",  bus.busy,  1'b1);
      tick();
      chk("t1_done",     bus.done, 1'b1);
      chk("t1_done_busy", bus.busy, 1'b0);
      chk("t1_en_total", last_sum,  24);
      chk("t1_busy_len", last_busy, 8);
      tick();
      chk("t1_done_pulse", bus.done, 1'b0);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("t1_run_cycles", bus.run_cycles, 16'd8);
`endif

      // zero-length run
      bus.start = 1'b1; bus.k_len = 5'd0;
      tick();
      bus.start = 1'b0;
      chk("k0_done", bus.done,  1'b1);
      chk("k0_busy", bus.busy,  1'b0);
      chk("k0_en",   bus.pe_en, 8'h00);
      tick();
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("k0_run_cycles", bus.run_cycles, 16'd0);
`endif

      // k_len above K_MAX clamps to 16
      bus.start = 1'b1; bus.k_len = 5'd20;
      tick();
      bus.start = 1'b0;
      repeat (15) tick();
      chk("k20_addr15", bus.rd_addr, 4'd15);
      chk("k20_rd15",   bus.a_rd_en, 1'b1);
      tick();
      chk("k20_rd16",   bus.a_rd_en, 1'b0);
      wait_done(40);
      chk("k20_busy_len", last_busy, 21);
      tick();

      // start held high: back-to-back runs, k_len wandering
      bus.start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.k_len = KW'($urandom_range(1, 6));
         tick();
      end
      bus.start = 1'b0;
      wait_done(40);
      tick();

      // start and k_len changes during a run are ignored
      bus.start = 1'b1; bus.k_len = 5'd4;
      tick();
      bus.k_len = 5'd9;
      repeat (3) tick();
      bus.start = 1'b0;
      wait_done(40);
      chk("ign_busy_len", last_busy, 9);
      tick();

      // abort at c=4 of a k=3 run
      bus.start = 1'b1; bus.k_len = 5'd3;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy,  1'b0);
      chk("abort_done", bus.done,  1'b0);
      chk("abort_en",   bus.pe_en, 8'h00);
      bus.start = 1'b1; bus.k_len = 5'd2;
      tick();
      bus.start = 1'b0;
      chk("abort_restart", bus.busy, 1'b1);
      wait_done(40);
      tick();

      // asynchronous reset mid-run
      bus.start = 1'b1; bus.k_len = 5'd5;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",  bus.busy,    1'b0);
      chk("arst_en",    bus.pe_en,   8'h00);
      chk("arst_rd",    bus.a_rd_en, 1'b0);
      chk("arst_first", bus.pe_first, 8'h00);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("arst_run_cycles", bus.run_cycles, 16'd0);
`endif
      tick();
      rst = 1'b0;
      tick();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.k_len = KW'($urandom_range(0, 20));
         bus.abort = ($urandom_range(0, 24) == 0);
         tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
